// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: types and constants shared by the instruction encoder.
// The opcode map is the one the main control decoder consumes. The immediate
// limits give the signed byte-offset range that each instruction format can carry.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        K_LW     = 3'd0,
        K_SW     = 3'd1,
        K_RTYPE  = 3'd2,
        K_BRANCH = 3'd3,
        K_ITYPE  = 3'd4,
        K_JAL    = 3'd5,
        K_LUI    = 3'd6,
        K_RSVD   = 3'd7
    } kind_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Word-sized load/store always use funct3 = 010.
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -(1 << 20);
    localparam int IMM_J_MAX = (1 << 20) - 2;

    function automatic logic imm_in_range(input logic signed [31:0] v,
                                          input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous DEPTH x WIDTH FIFO. DEPTH must be a power of two.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   flush              empties the FIFO; overrides push and pop
//   push, push_data    write one entry (ignored when full)
//   pop                drop the head entry (ignored when empty)
//   head               current head entry
//   full, empty, count occupancy status
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: turns instruction descriptors into RV32I words and streams
// them into imem through a small FIFO, one word per address.
// Optional build macro INSTR_ENCODER_CHECKSUM_EN adds the checksum output.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   in_valid/in_ready                 descriptor handshake
//   in_kind, in_funct3, in_funct7b5,
//   in_rd, in_rs1, in_rs2, in_imm     descriptor fields
//   start                             flush, rewind address, clear flags
//   imem_we/imem_ready                write handshake
//   imem_addr, imem_wdata             write address and data
//   count                             FIFO occupancy
//   illegal, wrapped                  sticky status flags
//   checksum (optional)               XOR of all committed words
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_kind,
    input  logic [2:0]              in_funct3,
    input  logic                    in_funct7b5,
    input  logic [4:0]              in_rd,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    input  logic [31:0]             in_imm,
    input  logic                    start,
    output logic                    imem_we,
    input  logic                    imem_ready,
    output logic [ADDR_W-1:0]       imem_addr,
    output logic [31:0]             imem_wdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    illegal,
    output logic                    wrapped
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]             checksum
`endif
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    kind_e              kind;
    logic signed [31:0] imm_s;
    logic [31:0]        enc_word;
    logic               enc_legal;
    logic               accept, push, pop;
    logic [31:0]        fifo_head;
    logic               fifo_full, fifo_empty;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               illegal_q, illegal_d;
    logic               wrapped_q, wrapped_d;

    assign kind  = kind_e'(in_kind);
    assign imm_s = in_imm;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (kind)
            K_LW: begin
                enc_word  = {in_imm[11:0], in_rs1, F3_WORD, in_rd, OP_LOAD};
                enc_legal = imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            K_SW: begin
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, F3_WORD, in_imm[4:0], OP_STORE};
                enc_legal = imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            K_RTYPE: begin
                enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
            end
            K_BRANCH: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], OP_BRANCH};
                enc_legal = !in_imm[0] && imm_in_range(imm_s, IMM_B_MIN, IMM_B_MAX);
            end
            K_ITYPE: begin
                enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ITYPE};
                enc_legal = imm_in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            K_JAL: begin
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                enc_legal = !in_imm[0] && imm_in_range(imm_s, IMM_J_MIN, IMM_J_MAX);
            end
            K_LUI: begin
                enc_word  = {in_imm[31:12], in_rd, OP_LUI};
                enc_legal = (in_imm[11:0] == 12'd0);
            end
            default: begin
                enc_legal = 1'b0;
            end
        endcase
    end

    // reset_n gates in_ready so nothing is offered while the block is held in reset.
    assign in_ready = reset_n && !fifo_full && !start;
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc_legal;
    assign imem_we  = !fifo_empty;
    assign pop      = imem_we && imem_ready && !start;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (start),
        .push      (push),
        .push_data (enc_word),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    // Stale storage must never show on the bus, so wdata is forced to zero while empty.
    assign imem_wdata = fifo_empty ? 32'd0 : fifo_head;
    assign imem_addr  = addr_q;
    assign illegal    = illegal_q;
    assign wrapped    = wrapped_q;

    always_comb begin
        addr_d    = addr_q;
        illegal_d = illegal_q;
        wrapped_d = wrapped_q;
        if (start) begin
            addr_d    = BASE;
            illegal_d = 1'b0;
            wrapped_d = 1'b0;
        end else begin
            if (pop) begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == {ADDR_W{1'b1}}) wrapped_d = 1'b1;
            end
            if (accept && !enc_legal) illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= BASE;
            illegal_q <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            illegal_q <= illegal_d;
            wrapped_q <= wrapped_d;
        end
    end

`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start)    checksum_d = '0;
        else if (pop) checksum_d = checksum_q ^ fifo_head;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) checksum_q <= '0;
        else          checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [2:0]  in_kind;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        start;
    logic        imem_ready;

    logic        in_ready, imem_we, illegal, wrapped;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  count;

    logic        in_ready2, imem_we2, illegal2, wrapped2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  count2;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0] checksum, checksum2;
`endif

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .start(start), .imem_we(imem_we), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
        .illegal(illegal), .wrapped(wrapped)
`ifdef INSTR_ENCODER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    // Narrow-address copy sharing all inputs, used for the wrap behaviour.
    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .start(start), .imem_we(imem_we2), .imem_ready(imem_ready),
        .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .count(count2),
        .illegal(illegal2), .wrapped(wrapped2)
`ifdef INSTR_ENCODER_CHECKSUM_EN
        , .checksum(checksum2)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit [31:0] mq[$];
    int        m_addr, m_addr2;
    bit        m_ill, m_wrap, m_wrap2;
    bit [31:0] m_csum;
    bit        last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Encodes directly from the ISA field layout using arithmetic on the byte offset.
    function automatic void ref_encode(input int kind, input int f3, input int f7b5,
                                       input int rd, input int rs1, input int rs2,
                                       input int imm, output bit [31:0] w, output bit legal);
        w = 0;
        legal = 1;
        case (kind)
            0: begin
                legal = (imm >= -2048) && (imm <= 2047);
                w = ((imm & 'hfff) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
            end
            1: begin
                legal = (imm >= -2048) && (imm <= 2047);
                w = (((imm >> 5) & 'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                    | ((imm & 31) << 7) | 'h23;
            end
            2: w = (f7b5 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
            3: begin
                legal = ((imm & 1) == 0) && (imm >= -4096) && (imm <= 4094);
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8)
                    | (((imm >> 11) & 1) << 7) | 'h63;
            end
            4: begin
                legal = (imm >= -2048) && (imm <= 2047);
                w = ((imm & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            end
            5: begin
                legal = ((imm & 1) == 0) && (imm >= -(1 << 20)) && (imm <= (1 << 20) - 2);
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3ff) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hff) << 12)
                    | (rd << 7) | 'h6f;
            end
            6: begin
                legal = ((imm & 'hfff) == 0);
                w = (imm & 32'hfffff000) | (rd << 7) | 'h37;
            end
            default: legal = 0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_addr = 0; m_addr2 = 0;
        m_ill = 0; m_wrap = 0; m_wrap2 = 0;
        m_csum = 0;
    endtask

    // One clock cycle: check outputs against the model, then advance both.
    task automatic step();
        bit        exp_rdy, exp_we, acc, pop, legal;
        bit [31:0] w, head;
        #1;
        exp_rdy = (mq.size() < DEPTH) && !start;
        exp_we  = (mq.size() != 0);
        head    = exp_we ? mq[0] : 32'd0;
        chk("in_ready", in_ready, exp_rdy);
        chk("imem_we", imem_we, exp_we);
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, head);
        chk("count", count, mq.size());
        chk("illegal", illegal, m_ill);
        chk("wrapped", wrapped, m_wrap);
        chk("addr2", imem_addr2, m_addr2);
        chk("wrapped2", wrapped2, m_wrap2);
        chk("wdata2", imem_wdata2, head);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        chk("checksum", checksum, m_csum);
`endif
        acc = in_valid && exp_rdy;
        pop = exp_we && imem_ready && !start;
        ref_encode(in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, int'(in_imm), w, legal);
        @(posedge clk);
        if (start) begin
            model_reset();
        end else begin
            if (pop) begin
                m_csum ^= head;
                void'(mq.pop_front());
                if (m_addr == 255) m_wrap = 1;
                m_addr = (m_addr + 1) % 256;
                if (m_addr2 == 3) m_wrap2 = 1;
                m_addr2 = (m_addr2 + 1) % 4;
            end
            if (acc) begin
                if (legal) mq.push_back(w);
                else m_ill = 1;
            end
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic set_desc(input int kind, input int f3, input int f7b5, input int rd,
                            input int rs1, input int rs2, input int imm);
        in_kind = 3'(kind); in_funct3 = 3'(f3); in_funct7b5 = 1'(f7b5);
        in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 32'(imm);
    endtask

    task automatic send(input int kind, input int f3, input int f7b5, input int rd,
                        input int rs1, input int rs2, input int imm);
        set_desc(kind, f3, f7b5, rd, rs1, rs2, imm);
        in_valid = 1;
        last_acc = 0;
        for (int i = 0; i < 20 && !last_acc; i++) step();
        chk("send_accept", last_acc, 1);
        in_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic drain();
        imem_ready = 1;
        for (int i = 0; i < 20 && mq.size() != 0; i++) step();
        #1 chk("drain_count", count, 0);
    endtask

    initial begin
        reset_n = 0; in_valid = 0; start = 0; imem_ready = 0;
        set_desc(0, 0, 0, 0, 0, 0, 0);
        model_reset();

        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_wrapped", wrapped, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        step();

        // LW x5, 8(x2)
        pulse_start();
        imem_ready = 1;
        send(0, 0, 0, 5, 2, 0, 8);
        #1;
        chk("lw_we", imem_we, 1);
        chk("lw_addr", imem_addr, 0);
        chk("lw_word", imem_wdata, 32'h00812283);
        step();
        #1 chk("lw_addr_after", imem_addr, 1);
        drain();

        // SW then BRANCH
        pulse_start();
        imem_ready = 0;
        send(1, 0, 0, 0, 2, 6, 12);
        send(3, 0, 0, 0, 1, 2, -4);
        #1;
        chk("sw_word", imem_wdata, 32'h00612623);
        chk("sw_addr", imem_addr, 0);
        imem_ready = 1;
        step();
        #1;
        chk("beq_word", imem_wdata, 32'hFE208EE3);
        chk("beq_addr", imem_addr, 1);
        drain();

        // Full FIFO backpressure with 5 LUIs
        pulse_start();
        imem_ready = 0;
        for (int k = 0; k < 4; k++) send(6, 0, 0, 1, 0, 0, 32'h12345000);
        set_desc(6, 0, 0, 1, 0, 0, 32'h12345000);
        in_valid = 1;
        step(); step();
        #1;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_word", imem_wdata, 32'h123450B7);
        imem_ready = 1;
        last_acc = 0;
        for (int i = 0; i < 20 && !last_acc; i++) step();
        chk("fifth_accept", last_acc, 1);
        in_valid = 0;
        drain();
        #1 chk("lui_final_addr", imem_addr, 5);

        // Illegal descriptors
        pulse_start();
        imem_ready = 1;
        send(3, 0, 0, 0, 1, 2, 3);
        #1;
        chk("ill_b_flag", illegal, 1);
        chk("ill_b_we", imem_we, 0);
        send(4, 0, 0, 3, 4, 0, 4096);
        send(7, 0, 0, 1, 1, 1, 0);
        #1;
        chk("ill_flag", illegal, 1);
        chk("ill_we", imem_we, 0);
        chk("ill_addr", imem_addr, 0);
        pulse_start();
        #1 chk("ill_cleared", illegal, 0);

        // Address wrap on the 2-bit instance
        pulse_start();
        imem_ready = 1;
        for (int k = 0; k < 5; k++) begin
            send(4, 0, 0, k + 1, 0, 0, k);
            #1 chk("wrap_addr2", imem_addr2, k % 4);
            step();
            #1 chk("wrap_flag2", wrapped2, (k >= 3) ? 1 : 0);
        end

        // Reset in the middle of a write
        pulse_start();
        imem_ready = 1;
        send(5, 0, 0, 1, 0, 0, 2048);
        send(2, 0, 1, 3, 4, 5, 0);
        imem_ready = 0;
        for (int k = 0; k < 3; k++) send(4, 1, 0, k, k, 0, -k);
        #2;
        reset_n = 0;
        #1;
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_in_ready", in_ready, 0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        chk("mid_rst_csum", checksum, 0);
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1;
        imem_ready = 1;
        repeat (3) step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            int kind, sel, imm;
            kind = $urandom_range(0, 7);
            sel = $urandom_range(0, 3);
            case (sel)
                0: imm = int'($urandom_range(0, 4095)) - 2048;
                1: imm = int'($urandom_range(0, 8191)) - 4096;
                2: imm = int'($urandom);
                default: imm = int'($urandom & 32'hfffff000);
            endcase
            set_desc(kind, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), imm);
            in_valid = ($urandom_range(0, 3) != 0);
            imem_ready = ($urandom_range(0, 2) != 0);
            start = ($urandom_range(0, 39) == 0);
            step();
        end
        in_valid = 0;
        start = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Producer-side counterpart of the main control decoder: takes structured instruction descriptors and emits RV32I machine words using the same opcode map the decoder consumes (lw, sw, R-type, beq, I-type ALU, jal, lui).
- Encoded words go through a small FIFO and are written sequentially into instruction memory through a write port with backpressure.
- Used by the testbench and boot path to load programs into imem.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- ADDR_W, 8, imem word-address width.
- BASE_ADDR, 0, first word address after reset or start.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- in_kind  in  3  0=LW 1=SW 2=RTYPE 3=BRANCH 4=ITYPE 5=JAL 6=LUI 7=reserved.
- in_funct3  in  3  funct3; ignored for LW/SW (forced 010), JAL and LUI.
- in_funct7b5  in  1  instr[30] for RTYPE; 0 elsewhere.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_imm  in  32  signed immediate in byte units; raw upper value for LUI.
- start  in  1  pulse: flush FIFO, address to BASE_ADDR, clear sticky flags.
- imem_we  out  1  write request.
- imem_ready  in  1  write accepted when imem_we && imem_ready.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  instruction word.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- illegal  out  1  sticky: descriptor rejected.
- wrapped  out  1  sticky: address wrapped.

Behaviour:
- Reset and all outputs: asynchronous and active-low, as already decided (one clock, clk). During reset: in_ready=0; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0; count=0; illegal=0; wrapped=0.
- Backpressure: in_ready = !full && !start, registered-independent (combinational from count and start).
- Encoding (combinational on input, written into FIFO at the accepting edge):
  - LW: I-format, opcode 0000011.
  - SW: S-format, opcode 0100011.
  - RTYPE: opcode 0110011, funct7 = {0, in_funct7b5, 00000}.
  - BRANCH: B-format, opcode 1100011.
  - ITYPE: I-format, opcode 0010011.
  - JAL: J-format, opcode 1101111.
  - LUI: U-format, opcode 0110111, using in_imm[31:12].
- Legality checks; an accepted descriptor that fails any of these is dropped and illegal is set:
  - I and S immediates must lie in [-2048, 2047].
  - B immediates must be even and lie in [-4096, 4094].
  - J immediates must be even and lie in [-2^20, 2^20-2].
  - LUI requires in_imm[11:0]=0.
  - kind 7 is illegal.
- Latency: a word accepted at edge N has imem_we=1 from cycle N+1, with imem_wdata equal to the FIFO head.
- imem_we = !empty. A pop occurs on imem_we && imem_ready; imem_addr then increments by 1 at that edge.
- Address wrap: 2^ADDR_W-1 → 0 and sets wrapped.
- Simultaneous push and pop: count unchanged; ordering preserved.
- Full: in_ready=0, and a descriptor held by in_valid is not lost.
- Empty: imem_we=0; imem_addr holds.
- start has priority over push and pop in the same cycle. It flushes the FIFO (count=0), sets the address to BASE_ADDR, and clears illegal and wrapped. imem_we drops in the next cycle.
- Reset mid-write: FIFO contents are discarded with no partial write; imem_we=0 immediately.

Optional Feature:
- INSTR_ENCODER_CHECKSUM_EN
  - Defined: adds output checksum[31:0], the XOR of every word committed (pop edge). Reset and start clear it to 0.
  - Undefined: the port and logic are absent; no other behaviour changes.

Decomposition:
- instr_enc_pkg:
  - kind enum (LW..LUI, RSVD).
  - 7-bit opcode constants shared with maindec (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL, OP_LUI).
  - immediate range constants.
- Sub-module: instr_fifo, a synchronous DEPTH×32 FIFO with push, pop, full, empty and count. Encoding, checks, address counter and flags stay in the top.

Test Plan:
- LW, rd=5, rs1=2, imm=8, imem_ready=1 → next cycle imem_we=1, addr=0, wdata=0x00812283; addr becomes 1 after the write.
- SW rs2=6, rs1=2, imm=12, then BRANCH funct3=000, rs1=1, rs2=2, imm=-4 → words 0x00612623 at addr 0 and 0xFE208EE3 at addr 1.
- imem_ready=0; offer 5 LUI rd=1, imm=0x12345000 → 4 accepted, count=4, in_ready=0. Raise imem_ready → four writes of 0x123450B7 at addr 0..3, then the 5th is accepted and written at addr 4.
- BRANCH imm=3, then ITYPE imm=4096, then kind=7 → illegal=1, no imem_we, addr unchanged. start → illegal=0.
- ADDR_W=2, 5 consecutive writes → addresses 0,1,2,3,0, with wrapped=1 after the 4th.
- 3 words queued with imem_ready=0, then reset_n=0 mid-cycle → imem_we=0, count=0, addr=BASE_ADDR at once. After release no stale word is written. With INSTR_ENCODER_CHECKSUM_EN, checksum=0.
